// File: rtl/br_cond_unit.sv
// LC-3 branch resolution: holds the NZP condition register and resolves a BR
// instruction into taken/target through a four-state sequencer with a done pulse.
module br_cond_unit (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        LD_CC,
   input  logic [15:0] Bus,
   input  logic        start,
   input  logic [15:0] IR,
   input  logic [15:0] PC,
   output logic        n,
   output logic        z,
   output logic        p,
   output logic        BEN,
   output logic        busy,
   output logic        done,
   output logic        taken,
   output logic [15:0] target
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EVAL = 2'd1;
   localparam logic [1:0] ADDR = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]  state;
   logic [11:0] irQ;
   logic [15:0] pcQ;
   logic [15:0] offsetExt;
   logic [15:0] branchTarget;
   logic        benNext;
   logic        unusedOpcode;

   // The opcode field is never inspected; the sequencer only starts us on BR.
   assign unusedOpcode = &{1'b0, IR[15:12]};

   assign offsetExt    = {{7{irQ[8]}}, irQ[8:0]};
   assign branchTarget = pcQ + offsetExt;
   assign benNext      = |(irQ[11:9] & {n, z, p});

   // Condition register loads in any state; exactly one of n/z/p is ever set.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         {n, z, p} <= 3'b010;
      end else if (LD_CC) begin
         if (Bus == 16'h0000)
            {n, z, p} <= 3'b010;
         else if (Bus[15])
            {n, z, p} <= 3'b100;
         else
            {n, z, p} <= 3'b001;
      end
   end

   // Sequencer: EVAL samples the pre-edge NZP value, so a same-edge LD_CC is
   // only seen by the next evaluation. Results persist until overwritten.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state  <= IDLE;
         irQ    <= 12'h000;
         pcQ    <= 16'h0000;
         BEN    <= 1'b0;
         taken  <= 1'b0;
         target <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  irQ   <= IR[11:0];
                  pcQ   <= PC;
                  state <= EVAL;
               end
            end
            EVAL: begin
               BEN   <= benNext;
               state <= ADDR;
            end
            ADDR: begin
               taken  <= BEN;
               target <= BEN ? branchTarget : pcQ;
               state  <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_br_cond_unit.sv
// Directed self-checking bench for br_cond_unit: CC loads, taken/not-taken
// branches, wrap-around, LD_CC/start hazards and asynchronous reset mid-flight.
module tb_br_cond_unit;

   logic        Clk;
   logic        Reset;
   logic        LD_CC;
   logic [15:0] Bus;
   logic        start;
   logic [15:0] IR;
   logic [15:0] PC;
   logic        n, z, p;
   logic        BEN, busy, done, taken;
   logic [15:0] target;

   int checks;
   int errors;
   int doneCount;

   br_cond_unit dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .LD_CC  (LD_CC),
      .Bus    (Bus),
      .start  (start),
      .IR     (IR),
      .PC     (PC),
      .n      (n),
      .z      (z),
      .p      (p),
      .BEN    (BEN),
      .busy   (busy),
      .done   (done),
      .taken  (taken),
      .target (target)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drives one CC load through a clock edge.
   task automatic applyStimulus(input logic [15:0] busVal);
      LD_CC = 1'b1;
      Bus   = busVal;
      tick();
      LD_CC = 1'b0;
   endtask

   // Full branch: start at E0, checks through E3.
   task automatic runBranch(input string tag, input logic [15:0] irVal,
                            input logic [15:0] pcVal, input logic expTaken,
                            input logic [15:0] expTarget);
      start = 1'b1;
      IR    = irVal;
      PC    = pcVal;
      tick();
      start = 1'b0;
      checkOutput({tag, "_busyE0"}, {15'd0, busy}, 16'd1);
      tick();
      checkOutput({tag, "_benE1"}, {15'd0, BEN}, {15'd0, expTaken});
      tick();
      checkOutput({tag, "_doneE2"}, {15'd0, done}, 16'd1);
      checkOutput({tag, "_taken"}, {15'd0, taken}, {15'd0, expTaken});
      checkOutput({tag, "_target"}, target, expTarget);
      tick();
      checkOutput({tag, "_doneE3"}, {15'd0, done}, 16'd0);
      checkOutput({tag, "_idleE3"}, {15'd0, busy}, 16'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      Reset  = 1'b1;
      LD_CC  = 1'b0;
      Bus    = 16'h0000;
      start  = 1'b0;
      IR     = 16'h0000;
      PC     = 16'h0000;

      // Reset values must appear before any clock edge
      #2;
      checkOutput("rst_nzp", {13'd0, n, z, p}, 16'h0002);
      checkOutput("rst_busy", {15'd0, busy}, 16'd0);
      checkOutput("rst_done", {15'd0, done}, 16'd0);
      checkOutput("rst_target", target, 16'h0000);
      checkOutput("rst_taken", {15'd0, taken}, 16'd0);
      checkOutput("rst_ben", {15'd0, BEN}, 16'd0);
      Reset = 1'b0;
      tick();
      checkOutput("idle_busy", {15'd0, busy}, 16'd0);

      applyStimulus(16'h0000);
      checkOutput("cc_0000", {13'd0, n, z, p}, 16'h0002);
      applyStimulus(16'h8000);
      checkOutput("cc_8000", {13'd0, n, z, p}, 16'h0004);
      applyStimulus(16'h7FFF);
      checkOutput("cc_7FFF", {13'd0, n, z, p}, 16'h0001);
      applyStimulus(16'hFFFF);
      checkOutput("cc_FFFF", {13'd0, n, z, p}, 16'h0004);

      runBranch("taken_n", 16'h09FE, 16'h3001, 1'b1, 16'h2FFF);
      checkOutput("hold_target", target, 16'h2FFF);
      checkOutput("hold_ben", {15'd0, BEN}, 16'd1);

      applyStimulus(16'h0001);
      runBranch("nt_nz", 16'h0C05, 16'h4000, 1'b0, 16'h4000);
      runBranch("wrap", 16'h0E01, 16'hFFFF, 1'b1, 16'h0000);

      // LD_CC at the EVAL edge: EVAL still sees the old CC=001
      start = 1'b1;
      IR    = 16'h0400;
      PC    = 16'h1000;
      tick();
      start = 1'b0;
      LD_CC = 1'b1;
      Bus   = 16'h0000;
      tick();
      LD_CC = 1'b0;
      checkOutput("haz_eval_ben", {15'd0, BEN}, 16'd0);
      checkOutput("haz_eval_z", {15'd0, z}, 16'd1);
      tick();
      checkOutput("haz_eval_done", {15'd0, done}, 16'd1);
      checkOutput("haz_eval_target", target, 16'h1000);
      tick();

      // LD_CC at the start edge is seen by EVAL (CC becomes 001, mask p)
      start = 1'b1;
      IR    = 16'h0203;
      PC    = 16'h2000;
      LD_CC = 1'b1;
      Bus   = 16'h0001;
      tick();
      start = 1'b0;
      LD_CC = 1'b0;
      tick();
      tick();
      checkOutput("haz_start_taken", {15'd0, taken}, 16'd1);
      checkOutput("haz_start_target", target, 16'h2003);
      tick();

      // start pulsed in ADDR is ignored, exactly one done pulse
      start = 1'b1;
      IR    = 16'h0E01;
      PC    = 16'h5000;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      IR    = 16'h0E0F;
      PC    = 16'h6000;
      doneCount = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         start = 1'b0;
         if (done) doneCount++;
      end
      checkOutput("addr_start_dones", doneCount[15:0], 16'd1);
      checkOutput("addr_start_target", target, 16'h5001);
      checkOutput("addr_start_busy", {15'd0, busy}, 16'd0);

      // Asynchronous reset while in ADDR
      start = 1'b1;
      IR    = 16'h0E10;
      PC    = 16'h6000;
      tick();
      start = 1'b0;
      tick();
      checkOutput("pre_rst_busy", {15'd0, busy}, 16'd1);
      Reset = 1'b1;
      #1;
      checkOutput("mid_rst_nzp", {13'd0, n, z, p}, 16'h0002);
      checkOutput("mid_rst_busy", {15'd0, busy}, 16'd0);
      checkOutput("mid_rst_ben", {15'd0, BEN}, 16'd0);
      checkOutput("mid_rst_taken", {15'd0, taken}, 16'd0);
      checkOutput("mid_rst_target", target, 16'h0000);
      #1;
      Reset = 1'b0;
      doneCount = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done) doneCount++;
      end
      checkOutput("post_rst_dones", doneCount[15:0], 16'd0);
      runBranch("post_rst", 16'h0405, 16'h7000, 1'b1, 16'h7005);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
